// File: rtl/ecc_scrub_ctrl.sv
// ecc_scrub_ctrl: background scrubber for one ECC-protected SRAM bank.
// Reads the bank one word at a time and passes each raw codeword to an external
// corrector. Correctable words are written back unless a functional write to the
// same address lands first. Functional traffic always has priority on the bank port.
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   scrub_trigger_i              request one scrub step (pulse or level)
//   bank_busy_i/we_i/addr_i      snoop of the functional bank access
//   scrub_req/we/addr/wdata_o    scrubber bank access
//   scrub_rdata_i                bank read data, valid the cycle after a read
//   ecc_in_o / ecc_out_i         raw codeword out, corrected codeword back
//   ecc_(un)correctable_i        corrector flags, consumed only in WAIT
//   nb_(un)corrected_o           saturating error counters
//   sweep_done_o                 one-cycle pulse after the address wraps to 0
module ecc_scrub_ctrl #(
  parameter int BankSize  = 256,
  parameter int DataWidth = 32,
  parameter int EccWidth  = 7,
  parameter int CntWidth  = 32,
  parameter int AddrWidth = $clog2(BankSize),
  localparam int WordWidth = DataWidth + EccWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 scrub_trigger_i,
  input  logic                 bank_busy_i,
  input  logic                 bank_we_i,
  input  logic [AddrWidth-1:0] bank_addr_i,
  output logic                 scrub_req_o,
  output logic                 scrub_we_o,
  output logic [AddrWidth-1:0] scrub_addr_o,
  output logic [WordWidth-1:0] scrub_wdata_o,
  input  logic [WordWidth-1:0] scrub_rdata_i,
  output logic [WordWidth-1:0] ecc_in_o,
  input  logic [WordWidth-1:0] ecc_out_i,
  input  logic                 ecc_correctable_i,
  input  logic                 ecc_uncorrectable_i,
  output logic [CntWidth-1:0]  nb_corrected_o,
  output logic [CntWidth-1:0]  nb_uncorrectable_o,
  output logic                 sweep_done_o
);
  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(BankSize - 1);
  typedef enum logic [1:0] {IDLE, READ, WAIT, WRITE} state_e;
  state_e state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic pend_q, pend_d, abort_q, abort_d, sweep_q, sweep_d;
  logic [WordWidth-1:0] wbuf_q, wbuf_d;
  logic [CntWidth-1:0] ncor_q, ncor_d, nunc_q, nunc_d;
  logic req, we, adv, hazard;
  assign hazard = bank_busy_i & bank_we_i & (bank_addr_i == addr_q);
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pend_d  = pend_q | scrub_trigger_i;
    abort_d = abort_q;
    wbuf_d  = wbuf_q;
    ncor_d  = ncor_q;
    nunc_d  = nunc_q;
    sweep_d = 1'b0;
    req     = 1'b0;
    we      = 1'b0;
    adv     = 1'b0;
    case (state_q)
      IDLE: begin
        pend_d = 1'b0;
        if (scrub_trigger_i | pend_q) state_d = READ;
      end
      READ: if (!bank_busy_i) begin
        req     = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        // A functional write in this very cycle must still cancel the write-back.
        abort_d = hazard;
        if (ecc_uncorrectable_i) begin
          nunc_d  = nunc_q + {{(CntWidth-1){1'b0}}, ~&nunc_q};
          adv     = 1'b1;
          state_d = IDLE;
        end else if (ecc_correctable_i) begin
          wbuf_d  = ecc_out_i;
          ncor_d  = ncor_q + {{(CntWidth-1){1'b0}}, ~&ncor_q};
          state_d = WRITE;
        end else begin
          adv     = 1'b1;
          state_d = IDLE;
        end
      end
      WRITE: begin
        abort_d = abort_q | hazard;
        if (!bank_busy_i) begin
          req     = ~abort_q;
          we      = ~abort_q;
          adv     = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
    if (adv) begin
      addr_d  = (addr_q == LastAddr) ? '0 : addr_q + AddrWidth'(1);
      sweep_d = (addr_q == LastAddr);
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      pend_q  <= 1'b0;
      abort_q <= 1'b0;
      sweep_q <= 1'b0;
      wbuf_q  <= '0;
      ncor_q  <= '0;
      nunc_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pend_q  <= pend_d;
      abort_q <= abort_d;
      sweep_q <= sweep_d;
      wbuf_q  <= wbuf_d;
      ncor_q  <= ncor_d;
      nunc_q  <= nunc_d;
    end
  end
  assign scrub_req_o        = req;
  assign scrub_we_o         = we;
  assign scrub_addr_o       = addr_q;
  assign scrub_wdata_o      = wbuf_q;
  assign ecc_in_o           = scrub_rdata_i;
  assign nb_corrected_o     = ncor_q;
  assign nb_uncorrectable_o = nunc_q;
  assign sweep_done_o       = sweep_q;
endmodule

// File: doc/ecc_scrub_ctrl.md
# ecc_scrub_ctrl

Background scrubber for one ECC-protected SRAM bank. It reads the bank one word at a time and passes each raw codeword through an external ECC corrector (the Hsiao/Hamming correction stage). When the corrector reports a correctable error, it writes the corrected codeword back. It sits directly downstream of the corrector's outputs and shares the bank port with functional traffic, which always has priority. It also keeps saturating counts of corrected and uncorrectable errors.

## Interface
Parameters:
- BankSize, 256: number of codewords in the bank; must be ≥ 2.
- DataWidth, 32: payload bits per word.
- EccWidth, 7: ECC bits per word, matching the corrector configuration. WordWidth = DataWidth+EccWidth.
- CntWidth, 32: width of each error counter.
- AddrWidth, $clog2(BankSize): dependent, do not override.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- scrub_trigger_i  in  1  request one scrub step (pulse or level).
- bank_busy_i  in  1  functional access owns the bank port this cycle.
- bank_we_i  in  1  functional access is a write (snoop; valid with bank_busy_i).
- bank_addr_i  in  AddrWidth  functional access address (snoop).
- scrub_req_o  out  1  scrubber bank access.
- scrub_we_o  out  1  1 = write-back, 0 = read.
- scrub_addr_o  out  AddrWidth  bank address.
- scrub_wdata_o  out  WordWidth  corrected codeword to write.
- scrub_rdata_i  in  WordWidth  bank read data; valid the cycle after a read request.
- ecc_in_o  out  WordWidth  raw codeword sent to the corrector.
- ecc_out_i  in  WordWidth  corrected codeword from the corrector (combinational return).
- ecc_correctable_i  in  1  corrector flag.
- ecc_uncorrectable_i  in  1  corrector flag.
- nb_corrected_o  out  CntWidth  correctable-error count, saturating.
- nb_uncorrectable_o  out  CntWidth  uncorrectable-error count, saturating.
- sweep_done_o  out  1  one-cycle pulse when the address wraps to 0.

## Operation
- FSM states: IDLE, READ, WAIT, WRITE.
- IDLE
  - If scrub_trigger_i or pending is set, clear pending and go to READ.
- READ
  - If bank_busy_i=1, stay in READ with scrub_req_o=0.
  - Otherwise drive scrub_req_o=1, scrub_we_o=0, scrub_addr_o=addr, then go to WAIT.
- WAIT
  - ecc_in_o = scrub_rdata_i, and the corrector flags are sampled this cycle.
  - If ecc_uncorrectable_i=1: increment nb_uncorrectable_o, advance addr, go to IDLE. No write-back.
  - Else if ecc_correctable_i=1: latch ecc_out_i into wbuf, increment nb_corrected_o, clear the abort flag, go to WRITE.
  - Else: advance addr, go to IDLE.
  - If both flags are set, the uncorrectable path is taken.
- WRITE
  - If bank_busy_i=1, stay in WRITE with scrub_req_o=0.
  - Otherwise drive scrub_req_o=1, scrub_we_o=1, scrub_wdata_o=wbuf, advance addr, go to IDLE.
  - If the abort flag is set, drop the write (scrub_req_o stays 0), advance addr, go to IDLE. The counter is not decremented.
- Write-back hazard: in WAIT and WRITE, a functional access with bank_busy_i & bank_we_i & (bank_addr_i==addr) sets the abort flag. This prevents stale data from overwriting a fresh functional write.
- Trigger handling: scrub_trigger_i outside IDLE sets pending. Multiple such triggers merge into a single pending step.
- Address advance:
  - addr = (addr==BankSize-1) ? 0 : addr+1.
  - sweep_done_o pulses on the cycle following the wrap.
- Counters hold at all-ones; they do not wrap.
- ecc_in_o equals scrub_rdata_i in every state. The corrector flags are only consumed in WAIT.

## Timing
- Reset values: state IDLE, addr 0, pending 0, abort 0, wbuf 0, counters 0.
- Outputs during reset: scrub_req_o=0, scrub_we_o=0, sweep_done_o=0.
- Reset asserted mid-operation returns to IDLE immediately. Any in-flight write-back is discarded.
- Uncontended clean word (trigger at T): read request at T+1, WAIT at T+2, IDLE at T+3, addr incremented at T+3.
- Uncontended correctable word: read at T+1, WAIT at T+2, write request at T+3, IDLE at T+4.
- Each cycle of bank_busy_i in READ or WRITE adds one cycle of latency. There is no timeout.
- Counter updates are visible the cycle after WAIT.
- At most one scrubber access is outstanding. scrub_req_o is never high while bank_busy_i is high.

## Test plan
- Reset, then trigger at addr 0 with a clean word: one read to addr 0, no write, counters stay 0, addr becomes 1 at T+3.
- Bank word 5 has a single-bit flip; trigger with addr=5: ecc_correctable_i=1, write of the corrected word to 5 at T+3, nb_corrected_o=1.
- Double-bit error at addr 7: nb_uncorrectable_o=1, no write request, addr advances to 8.
- Correctable error at addr 3 plus a functional write to addr 3 during the WAIT cycle: no write-back, nb_corrected_o=1, addr advances to 4.
- Hold bank_busy_i for 4 cycles in READ while pulsing the trigger twice: no scrubber request while busy, one pending step executes afterward, 2 reads total.
- BankSize=4, 4 triggers: addresses 0,1,2,3 read in order, sweep_done_o pulses once, addr returns to 0. Preload nb_corrected_o to all-ones via correctable errors: the counter holds.
